ysyx_22050550_pcgen: RTL and testbench

- Parametrised program-counter generator for the IFU front end.
- Holds the fetch PC and presents it to the fetch stage over a valid/ready handshake.
- Applies prioritised redirects from the trap unit (ecall/mret/interrupt) and the branch unit (jal/jalr/branch), and supports a halt/resume mode.
- Contains a return-address stack (RAS) of configurable depth that the decoder uses for call/return prediction.

---
 rtl/ysyx_22050550_pcgen.sv | 130 +++++++++++++
 tb/tb_ysyx_22050550_pcgen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050550_pcgen.sv
// Program-counter generator for the IFU front end: holds the fetch PC, applies
// prioritised trap/branch redirects, supports halt/resume, and hosts a small
// return-address stack used by the decoder for call/return prediction.
module ysyx_22050550_pcgen #(
  parameter int unsigned XLEN       = 64,
  parameter logic [63:0] RESET_PC   = 64'h8000_0000,
  parameter int unsigned INST_BYTES = 4,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic            clock,
  input  logic            reset,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_pc,
  input  logic            halt_req,
  output logic            halted,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_pc,
  input  logic            ras_pop,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty
);

  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [XLEN-1:0] ResetPc = RESET_PC[XLEN-1:0];

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fire;

  // A redirect cycle never presents a fetch request.
  assign out_valid = (state_q == StRun) && !trap_valid && !br_valid;
  assign fire      = out_valid && out_ready;
  assign out_pc    = pc_q;
  assign halted    = (state_q == StHalt);

  // Next state: trap always lands in RUN; IDLE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    if (trap_valid) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StRun;
        StRun:   if (halt_req) state_d = StHalt;
        StHalt:  state_d = StHalt;
        default: state_d = StIdle;
      endcase
    end
  end

  // Next PC in priority order: trap, branch (not in HALT), sequential fire, hold.
  always_comb begin
    pc_d = pc_q;
    if (trap_valid) begin
      pc_d = trap_pc;
    end else if (br_valid && (state_q != StHalt)) begin
      pc_d = {br_pc[XLEN-1:1], 1'b0};
    end else if (fire) begin
      pc_d = pc_q + XLEN'(INST_BYTES);
    end
  end

  // PC and state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= ResetPc;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Return-address stack: circular buffer, oldest entry overwritten when full.
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PtrW-1:0] tp_q, tp_d, wr_idx;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ras_we;

  assign ras_empty = (cnt_q == '0);
  assign ras_top   = ras_empty ? '0 : ras_q[tp_q];

  // RAS pointer/count update; push+pop on a non-empty stack replaces the top.
  always_comb begin
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    ras_we = 1'b0;
    wr_idx = tp_q;
    if (ras_push && (!ras_pop || ras_empty)) begin
      tp_d   = tp_q + PtrW'(1);
      wr_idx = tp_q + PtrW'(1);
      ras_we = 1'b1;
      if (cnt_q != CntW'(RAS_DEPTH)) cnt_d = cnt_q + CntW'(1);
    end else if (ras_push && ras_pop) begin
      ras_we = 1'b1;
    end else if (ras_pop && !ras_empty) begin
      tp_d  = tp_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // RAS pointer and count registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  // RAS entry storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
    end else if (ras_we) begin
      ras_q[wr_idx] <= ras_push_pc;
    end
  end

endmodule

// File: tb/tb_ysyx_22050550_pcgen.sv
// Bench for ysyx_22050550_pcgen: directed plan steps followed by random
// stimulus, all compared against a queue/arithmetic reference model.
module tb_ysyx_22050550_pcgen;

  localparam int unsigned XLEN  = 64;
  localparam logic [63:0] RPC   = 64'h8000_0000;
  localparam int unsigned DEPTH = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic            br_valid;
  logic [XLEN-1:0] br_pc;
  logic            halt_req;
  logic            halted;
  logic            ras_push;
  logic [XLEN-1:0] ras_push_pc;
  logic            ras_pop;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;

  ysyx_22050550_pcgen #(
    .XLEN      (XLEN),
    .RESET_PC  (RPC),
    .INST_BYTES(4),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .trap_valid (trap_valid),
    .trap_pc    (trap_pc),
    .br_valid   (br_valid),
    .br_pc      (br_pc),
    .halt_req   (halt_req),
    .halted     (halted),
    .ras_push   (ras_push),
    .ras_push_pc(ras_push_pc),
    .ras_pop    (ras_pop),
    .ras_top    (ras_top),
    .ras_empty  (ras_empty)
  );

  always #5 clock = ~clock;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state.
  logic [63:0] m_pc;
  bit          m_idle;
  bit          m_halt;
  logic [63:0] m_ras[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = RPC;
    m_idle = 1'b1;
    m_halt = 1'b0;
    m_ras.delete();
  endtask

  function automatic logic [63:0] m_top();
    return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 64'h0;
  endfunction

  // Check all outputs mid-cycle, then advance one clock and update the model.
  task automatic tick();
    bit m_valid;
    #1;
    m_valid = !m_idle && !m_halt && !trap_valid && !br_valid;
    check("out_valid", {63'h0, out_valid}, {63'h0, m_valid});
    check("out_pc", out_pc, m_pc);
    check("halted", {63'h0, halted}, {63'h0, m_halt});
    check("ras_top", ras_top, m_top());
    check("ras_empty", {63'h0, ras_empty}, {63'h0, (m_ras.size() == 0)});
    @(posedge clock);
    if (trap_valid)                 m_pc = trap_pc;
    else if (br_valid && !m_halt)   m_pc = br_pc & ~64'h1;
    else if (m_valid && out_ready)  m_pc = m_pc + 64'd4;
    if (trap_valid) begin
      m_idle = 1'b0;
      m_halt = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (halt_req) begin
      m_halt = 1'b1;
    end
    if (ras_push && ras_pop && m_ras.size() > 0) begin
      m_ras[m_ras.size()-1] = ras_push_pc;
    end else if (ras_push) begin
      m_ras.push_back(ras_push_pc);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end else if (ras_pop && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    trap_valid  = 1'b0;
    trap_pc     = '0;
    br_valid    = 1'b0;
    br_pc       = '0;
    halt_req    = 1'b0;
    ras_push    = 1'b0;
    ras_push_pc = '0;
    ras_pop     = 1'b0;
  endtask

  initial begin
    clear_inputs();
    out_ready = 1'b0;
    reset     = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    check("rst_valid", {63'h0, out_valid}, 64'h0);
    check("rst_pc", out_pc, RPC);
    check("rst_halted", {63'h0, halted}, 64'h0);
    check("rst_empty", {63'h0, ras_empty}, 64'h1);
    check("rst_top", ras_top, 64'h0);
    @(negedge clock);
    reset     = 1'b1;
    out_ready = 1'b1;

    // Startup: one IDLE cycle, then sequential fetch.
    tick();
    check("seq_pc0", out_pc, 64'h8000_0000);
    tick();
    check("seq_pc1", out_pc, 64'h8000_0004);
    tick();
    check("seq_pc2", out_pc, 64'h8000_0008);

    // Back-pressure holds the PC.
    out_ready = 1'b0;
    repeat (3) tick();
    check("bp_hold", out_pc, 64'h8000_0008);
    out_ready = 1'b1;
    tick();
    check("bp_adv", out_pc, 64'h8000_000C);

    // Trap beats branch; branch target has bit0 cleared.
    trap_valid = 1'b1; trap_pc = 64'h8000_1000;
    br_valid   = 1'b1; br_pc   = 64'h8000_0201;
    tick();
    clear_inputs();
    check("trap_prio", out_pc, 64'h8000_1000);
    br_valid = 1'b1; br_pc = 64'h8000_0201;
    tick();
    clear_inputs();
    check("br_align", out_pc, 64'h8000_0200);

    // Halt, ignored branch, trap resume.
    halt_req = 1'b1;
    tick();
    clear_inputs();
    check("halt_on", {63'h0, halted}, 64'h1);
    tick();
    br_valid = 1'b1; br_pc = 64'h8000_0300;
    tick();
    clear_inputs();
    check("halt_br_ign", out_pc, 64'h8000_0204);
    trap_valid = 1'b1; trap_pc = 64'h8000_2000;
    tick();
    clear_inputs();
    check("resume_halted", {63'h0, halted}, 64'h0);
    check("resume_pc", out_pc, 64'h8000_2000);

    // RAS overflow then drain.
    for (int i = 0; i < 5; i++) begin
      ras_push = 1'b1; ras_push_pc = 64'hA000 + 64'(i);
      tick();
    end
    clear_inputs();
    check("ras_full_top", ras_top, 64'hA004);
    ras_pop = 1'b1;
    tick();
    check("ras_pop1", ras_top, 64'hA003);
    tick();
    check("ras_pop2", ras_top, 64'hA002);
    tick();
    check("ras_pop3", ras_top, 64'hA001);
    tick();
    check("ras_pop4_empty", {63'h0, ras_empty}, 64'h1);
    tick();
    check("ras_pop5_empty", {63'h0, ras_empty}, 64'h1);
    clear_inputs();

    // Push+pop replaces the top without changing depth.
    ras_push = 1'b1; ras_push_pc = 64'hB001;
    tick();
    ras_push_pc = 64'hB002;
    tick();
    ras_pop = 1'b1; ras_push_pc = 64'hB003;
    tick();
    clear_inputs();
    check("ras_repl_top", ras_top, 64'hB003);
    ras_pop = 1'b1;
    tick();
    clear_inputs();
    check("ras_repl_below", ras_top, 64'hB001);

    // Asynchronous reset mid-stream.
    ras_push = 1'b1; ras_push_pc = 64'hC000;
    tick();
    clear_inputs();
    #2;
    reset = 1'b0;
    #1;
    check("arst_pc", out_pc, 64'h8000_0000);
    check("arst_empty", {63'h0, ras_empty}, 64'h1);
    check("arst_valid", {63'h0, out_valid}, 64'h0);
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Random phase.
    for (int n = 0; n < 400; n++) begin
      out_ready   = ($urandom_range(3) != 0);
      trap_valid  = ($urandom_range(11) == 0);
      trap_pc     = ($urandom_range(3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom};
      br_valid    = ($urandom_range(5) == 0);
      br_pc       = {$urandom, $urandom};
      halt_req    = ($urandom_range(9) == 0);
      ras_push    = ($urandom_range(2) == 0);
      ras_push_pc = {$urandom, $urandom};
      ras_pop     = ($urandom_range(2) == 0);
      tick();
    end
    clear_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
